dmem_arbiter: RTL and testbench

- Two-port arbiter and access sequencer in front of the single-port data memory.
- Port 0 is the core load/store unit; port 1 is the debug/DMA loader.
- Arbitrates per cycle with round-robin, drives the memory's MemWrite/MemRead/address/WritedataMem, and captures the combinational Data_out into a registered per-port response with a valid/ready handshake.
- Rejects out-of-range addresses with an error response, without touching memory.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_rsp_slot.sv | 64 ++++++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: widths, depth, port
// indices and the per-port response state encoding.
package dmem_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DATA_DEPTH = 32;

  // Port indices into the two-entry request/response vectors.
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  // Per-port state: waiting for a request, or holding a response.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } port_state_e;

endpackage

// File: rtl/dmem_rsp_slot.sv
// One requester's response slot: a two-state FSM that captures the access
// result on acceptance and holds it until the requester takes it.
module dmem_rsp_slot
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  accept_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  err_i,
  input  logic                  rsp_ready_i,
  output logic                  idle_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  port_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  // State and response registers; reset discards any pending response.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state: capture the result when accepted, release on handshake.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_i) begin
          state_d = ST_RSP;
          rdata_d = rdata_i;
          err_d   = err_i;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign idle_o      = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RSP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Port 0 is the core load/store unit, port 1 the debug/DMA loader.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_write,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  output logic                  p0_rsp_err,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_write,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  p1_rsp_err,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] WritedataMem,
  input  logic [DATA_WIDTH-1:0] Data_out
);

  // One bit wider than the address so any DATA_DEPTH fits in the compare.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  logic [1:0]            req_valid, req_write, rsp_ready;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];
  logic [1:0]            slot_idle, eligible, grant;
  logic [1:0]            rsp_valid, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata [2];
  logic                  last_grant_q, last_grant_d;
  logic                  sel, in_range;
  logic [DATA_WIDTH-1:0] cap_rdata;
  logic                  cap_err;

  assign req_valid    = {p1_req_valid, p0_req_valid};
  assign req_write    = {p1_req_write, p0_req_write};
  assign rsp_ready    = {p1_rsp_ready, p0_rsp_ready};
  assign req_addr[0]  = p0_req_addr;
  assign req_addr[1]  = p1_req_addr;
  assign req_wdata[0] = p0_req_wdata;
  assign req_wdata[1] = p1_req_wdata;

  assign eligible = req_valid & slot_idle;

  // Round-robin grant; nothing is granted while reset is held low.
  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    if (reset) begin
      if (eligible[PORT_CORE] && (!eligible[PORT_DBG] || last_grant_q == PORT_DBG)) begin
        grant[PORT_CORE] = 1'b1;
        last_grant_d     = PORT_CORE;
      end else if (eligible[PORT_DBG]) begin
        grant[PORT_DBG] = 1'b1;
        last_grant_d    = PORT_DBG;
      end
    end
  end

  // Last-grant pointer; resets to the debug port so the core wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= PORT_DBG;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign p0_req_ready = grant[PORT_CORE];
  assign p1_req_ready = grant[PORT_DBG];

  assign sel      = grant[PORT_DBG];
  assign in_range = {1'b0, req_addr[sel]} < DEPTH_LIMIT;

  // Memory mux and response capture; out-of-range grants never reach memory.
  always_comb begin
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    address      = '0;
    WritedataMem = '0;
    cap_rdata    = '0;
    cap_err      = 1'b0;
    if (|grant) begin
      cap_err = !in_range;
      if (in_range) begin
        address  = req_addr[sel];
        MemWrite = req_write[sel];
        MemRead  = !req_write[sel];
        if (req_write[sel]) begin
          WritedataMem = req_wdata[sel];
        end else begin
          cap_rdata = Data_out;
        end
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_slot
    dmem_rsp_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst_n_i    (reset),
      .accept_i   (grant[gi]),
      .rdata_i    (cap_rdata),
      .err_i      (cap_err),
      .rsp_ready_i(rsp_ready[gi]),
      .idle_o     (slot_idle[gi]),
      .rsp_valid_o(rsp_valid[gi]),
      .rsp_rdata_o(rsp_rdata[gi]),
      .rsp_err_o  (rsp_err[gi])
    );
  end

  assign p0_rsp_valid = rsp_valid[PORT_CORE];
  assign p1_rsp_valid = rsp_valid[PORT_DBG];
  assign p0_rsp_rdata = rsp_rdata[0];
  assign p1_rsp_rdata = rsp_rdata[1];
  assign p0_rsp_err   = rsp_err[PORT_CORE];
  assign p1_rsp_err   = rsp_err[PORT_DBG];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written corner
// sequences and random traffic, all checked against a transaction-level
// model of two requesters sharing one memory.
module tb_dmem_arbiter;

  localparam int DEPTH = 32;

  typedef struct packed {
    logic [1:0]       v, w, rr;
    logic [1:0][31:0] a, d;
  } in_t;

  typedef struct {
    in_t         in;
    logic [1:0]  rdy;
    bit          mw, mr, bus;
    logic [31:0] addr, wdm;
    logic [1:0]  rv, err;
    logic [31:0] rd0, rd1;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_clr = 1'b1;
  always #5 clk = ~clk;

  logic        p0_req_valid, p0_req_ready, p0_req_write, p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
  logic        p1_req_valid, p1_req_ready, p1_req_write, p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
  logic        MemWrite, MemRead;
  logic [31:0] address, WritedataMem, Data_out;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .MemWrite(MemWrite), .MemRead(MemRead), .address(address),
    .WritedataMem(WritedataMem), .Data_out(Data_out)
  );

  // The single-port memory the arbiter drives.
  logic [31:0] mem_stub [DEPTH];
  always_comb Data_out = (address < 32'(DEPTH)) ? mem_stub[address[4:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem_stub[i] <= 32'h0;
    end else if (MemWrite && address < 32'(DEPTH)) begin
      mem_stub[address[4:0]] <= WritedataMem;
    end
  end

  logic [1:0]       rdy, rsp_v, rsp_e;
  logic [1:0][31:0] rsp_d;
  assign rdy      = {p1_req_ready, p0_req_ready};
  assign rsp_v    = {p1_rsp_valid, p0_rsp_valid};
  assign rsp_e    = {p1_rsp_err, p0_rsp_err};
  assign rsp_d[0] = p0_rsp_rdata;
  assign rsp_d[1] = p1_rsp_rdata;

  // Reference model: who is waiting on a response, what it will be,
  // who was served last, and what memory holds.
  bit   [1:0]       m_busy;
  logic [1:0][31:0] m_rd;
  bit   [1:0]       m_err;
  bit               m_last;
  logic [31:0]      m_mem [DEPTH];
  int               m_g;

  int   n_vec, n_bad, cyc;
  in_t  cur;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL c%0d %s: got %h expected %h", cyc, nm, act, exp);
    end
  endtask

  function automatic in_t mk_in(bit v0, bit w0, logic [31:0] a0, logic [31:0] d0, bit rr0,
                                bit v1, bit w1, logic [31:0] a1, logic [31:0] d1, bit rr1);
    in_t r;
    r.v = {v1, v0}; r.w = {w1, w0}; r.rr = {rr1, rr0};
    r.a[0] = a0; r.a[1] = a1; r.d[0] = d0; r.d[1] = d1;
    return r;
  endfunction

  function automatic vec_t mk_vec(in_t in, logic [1:0] r, bit mw, bit mr, bit bus,
                                  logic [31:0] addr, logic [31:0] wdm, logic [1:0] rv,
                                  logic [1:0] err, logic [31:0] rd0, logic [31:0] rd1);
    vec_t x;
    x.in = in; x.rdy = r; x.mw = mw; x.mr = mr; x.bus = bus; x.addr = addr;
    x.wdm = wdm; x.rv = rv; x.err = err; x.rd0 = rd0; x.rd1 = rd1;
    return x;
  endfunction

  task automatic drive(input in_t x);
    cur = x;
    p0_req_valid = x.v[0]; p0_req_write = x.w[0]; p0_req_addr = x.a[0];
    p0_req_wdata = x.d[0]; p0_rsp_ready = x.rr[0];
    p1_req_valid = x.v[1]; p1_req_write = x.w[1]; p1_req_addr = x.a[1];
    p1_req_wdata = x.d[1]; p1_rsp_ready = x.rr[1];
  endtask

  task automatic model_reset();
    m_busy = 2'b00; m_last = 1'b1; m_g = -1;
  endtask

  // Predict this cycle's grant, memory bus and responses; compare all.
  task automatic mid_check();
    bit e0, e1, bus_chk;
    bit xmw, xmr;
    logic [31:0] xa, xw;
    e0 = !m_busy[0] && cur.v[0];
    e1 = !m_busy[1] && cur.v[1];
    if (e0 && e1) m_g = m_last ? 0 : 1;
    else if (e0) m_g = 0;
    else if (e1) m_g = 1;
    else m_g = -1;
    xmw = 0; xmr = 0; xa = 0; xw = 0; bus_chk = 1;
    if (m_g >= 0) begin
      if (cur.a[m_g] < 32'(DEPTH)) begin
        xa = cur.a[m_g]; xmw = cur.w[m_g]; xmr = !cur.w[m_g];
        xw = cur.w[m_g] ? cur.d[m_g] : 32'h0;
      end else begin
        bus_chk = 0;
      end
    end
    chk("p0_req_ready", p0_req_ready, 32'(m_g == 0));
    chk("p1_req_ready", p1_req_ready, 32'(m_g == 1));
    chk("MemWrite", MemWrite, 32'(xmw));
    chk("MemRead", MemRead, 32'(xmr));
    if (bus_chk) begin
      chk("address", address, xa);
      chk("WritedataMem", WritedataMem, xw);
    end
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("p%0d_rsp_valid", p), rsp_v[p], 32'(m_busy[p]));
      if (m_busy[p]) begin
        chk($sformatf("p%0d_rsp_rdata", p), rsp_d[p], m_rd[p]);
        chk($sformatf("p%0d_rsp_err", p), rsp_e[p], 32'(m_err[p]));
      end
    end
  endtask

  // Advance through the clock edge and apply it to the model.
  task automatic commit();
    bit inr;
    @(posedge clk);
    for (int p = 0; p < 2; p++) if (m_busy[p] && cur.rr[p]) m_busy[p] = 1'b0;
    if (m_g >= 0) begin
      inr = cur.a[m_g] < 32'(DEPTH);
      m_busy[m_g] = 1'b1;
      m_err[m_g]  = !inr;
      m_rd[m_g]   = (inr && !cur.w[m_g]) ? m_mem[cur.a[m_g][4:0]] : 32'h0;
      if (inr && cur.w[m_g]) m_mem[cur.a[m_g][4:0]] = cur.d[m_g];
      m_last = (m_g == 1);
    end
    cyc++;
    #1;
  endtask

  task automatic step(input in_t x);
    drive(x);
    #3;
    mid_check();
    commit();
  endtask

  task automatic reset_check();
    chk("rst MemWrite", MemWrite, 0);
    chk("rst MemRead", MemRead, 0);
    chk("rst req_ready", rdy, 0);
    chk("rst rsp_valid", rsp_v, 0);
    chk("rst rsp_err", rsp_e, 0);
    chk("rst p0_rsp_rdata", p0_rsp_rdata, 0);
    chk("rst p1_rsp_rdata", p1_rsp_rdata, 0);
  endtask

  in_t idle, x;

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    model_reset();
    idle = mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    tbl[0]  = mk_vec(mk_in(1, 1, 5, 32'hDEADBEEF, 1, 0, 0, 0, 0, 1), 2'b01, 1, 0, 1, 5, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0);
    tbl[1]  = mk_vec(mk_in(1, 0, 5, 0, 1, 0, 0, 0, 0, 1), 2'b00, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0);
    tbl[2]  = mk_vec(mk_in(1, 0, 5, 0, 1, 0, 0, 0, 0, 1), 2'b01, 0, 1, 1, 5, 0, 2'b00, 2'b00, 0, 0);
    tbl[3]  = mk_vec(idle, 2'b00, 0, 0, 1, 0, 0, 2'b01, 2'b00, 32'hDEADBEEF, 0);
    tbl[4]  = mk_vec(mk_in(0, 0, 0, 0, 1, 1, 1, 32, 32'h1234, 1), 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tbl[5]  = mk_vec(idle, 2'b00, 0, 0, 1, 0, 0, 2'b10, 2'b10, 0, 0);
    tbl[6]  = mk_vec(mk_in(1, 0, 0, 0, 1, 0, 0, 0, 0, 1), 2'b01, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    tbl[7]  = mk_vec(idle, 2'b00, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0);
    tbl[8]  = mk_vec(mk_in(0, 0, 0, 0, 1, 1, 1, 3, 32'hA5A5A5A5, 1), 2'b10, 1, 0, 1, 3, 32'hA5A5A5A5, 2'b00, 2'b00, 0, 0);
    tbl[9]  = mk_vec(mk_in(1, 0, 3, 0, 1, 0, 0, 0, 0, 1), 2'b01, 0, 1, 1, 3, 0, 2'b10, 2'b00, 0, 0);
    tbl[10] = mk_vec(idle, 2'b00, 0, 0, 1, 0, 0, 2'b01, 2'b00, 32'hA5A5A5A5, 0);
    tbl[11] = mk_vec(mk_in(1, 0, 1, 0, 1, 1, 0, 2, 0, 1), 2'b10, 0, 1, 1, 2, 0, 2'b00, 2'b00, 0, 0);
    tbl[12] = mk_vec(mk_in(1, 0, 1, 0, 1, 1, 0, 2, 0, 1), 2'b01, 0, 1, 1, 1, 0, 2'b10, 2'b00, 0, 0);
    tbl[13] = mk_vec(idle, 2'b00, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0);

    // Reset state.
    drive(idle);
    repeat (3) @(posedge clk);
    #1;
    reset_check();
    mem_clr = 1'b0;
    reset = 1'b1;

    // Simultaneous reads from reset: port 0 first, then strict alternation.
    for (int i = 0; i < 8; i++) begin
      drive(mk_in(1, 0, 1, 0, 1, 1, 0, 2, 0, 1));
      #3;
      mid_check();
      chk("alternation", rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
      commit();
    end
    step(idle);
    step(idle);

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].in);
      #3;
      mid_check();
      chk("tbl ready", rdy, tbl[i].rdy);
      chk("tbl MemWrite", MemWrite, 32'(tbl[i].mw));
      chk("tbl MemRead", MemRead, 32'(tbl[i].mr));
      if (tbl[i].bus) begin
        chk("tbl address", address, tbl[i].addr);
        chk("tbl WritedataMem", WritedataMem, tbl[i].wdm);
      end
      chk("tbl rsp_valid", rsp_v, tbl[i].rv);
      if (tbl[i].rv[0]) begin
        chk("tbl p0_rdata", p0_rsp_rdata, tbl[i].rd0);
        chk("tbl p0_err", p0_rsp_err, 32'(tbl[i].err[0]));
      end
      if (tbl[i].rv[1]) begin
        chk("tbl p1_rdata", p1_rsp_rdata, tbl[i].rd1);
        chk("tbl p1_err", p1_rsp_err, 32'(tbl[i].err[1]));
      end
      commit();
    end

    // Response backpressure on port 0 while port 1 keeps being served.
    step(mk_in(1, 0, 5, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++) begin
      drive(mk_in(1, 0, 5, 0, 0, 1, 0, 32'(i + 10), 0, 1));
      #3;
      mid_check();
      chk("bp p0_req_ready", p0_req_ready, 0);
      chk("bp p0_rsp_rdata", p0_rsp_rdata, 32'hDEADBEEF);
      chk("bp p1_req_ready", p1_req_ready, 32'(i % 2 == 0));
      commit();
    end
    step(idle);
    step(idle);

    // Reset asserted during a granted write with a response pending on port 1.
    step(mk_in(0, 0, 0, 0, 1, 1, 0, 3, 0, 0));
    drive(mk_in(1, 1, 7, 32'h77, 1, 0, 0, 0, 0, 0));
    reset = 1'b0;
    #3;
    reset_check();
    @(posedge clk);
    model_reset();
    cyc++;
    #1;
    reset = 1'b1;
    step(mk_in(1, 0, 7, 0, 1, 0, 0, 0, 0, 1));
    drive(idle);
    #3;
    mid_check();
    chk("post-reset addr7", p0_rsp_rdata, 32'h0);
    commit();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        x.v[p]  = 1'($urandom_range(0, 1));
        x.w[p]  = 1'($urandom_range(0, 1));
        x.rr[p] = ($urandom_range(0, 3) != 0);
        x.a[p]  = 32'($urandom_range(0, 36));
        x.d[p]  = $urandom;
      end
      step(x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
